// File: rtl/apb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared definitions for the APB completer: FSM state encoding,
//            register-bank geometry, ID register location and default value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Transfer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA0B0_0001;
  localparam int unsigned REG_COUNT        = 8;
  localparam int unsigned IDX_W            = 3;
  localparam logic [IDX_W-1:0] ID_IDX      = 3'd7;
  localparam int unsigned WCNT_W           = 4;

  // True when a word index addresses the read-only ID register
  function automatic logic is_id_word(input logic [IDX_W-1:0] idx);
    return (idx == ID_IDX);
  endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_slave_if
// Purpose  : APB bridge-to-completer bus bundle.
// Signals  : Pselx[2:0] select bus, Penable, Pwrite, Paddr[31:0],
//            Pwdata[31:0] (bridge -> completer);
//            Prdata[31:0], Pready, Pslverr (completer -> bridge)
// Modports : master (bridge side), slave (completer side)
// Revision : 1.0 - initial release
// ============================================================================
interface apb_slave_if;

  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface : apb_slave_if
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_slave_regfile
// Purpose  : 8 x 32-bit register bank. Words 0..6 are read/write storage,
//            word 7 is a constant ID register.
// Ports    : clk, rst (async, active-high)
//            we, waddr[2:0], wdata[31:0]  - single write port
//            raddr[2:0], rdata[31:0]      - combinational read port
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] words [REG_COUNT];

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_word
    if (i == int'(ID_IDX)) begin : g_id
      // No storage: writes to this index are simply never captured
      assign words[i] = ID_VALUE;
    end else begin : g_rw
      logic [31:0] word_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_q <= '0;
        end else if (we && (waddr == IDX_W'(i))) begin
          word_q <= wdata;
        end
      end
      assign words[i] = word_q;
    end
  end

  assign rdata = words[raddr];

endmodule : apb_slave_regfile
`default_nettype wire

// File: rtl/apb_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_slave
// Purpose  : APB completer with 7 R/W words plus a read-only ID word, a
//            programmable number of ACCESS-phase wait states and an error
//            response on writes to the ID word.
// Ports    : Hclk   - clock (rising edge)
//            Hreset - asynchronous active-high reset
//            bus    - apb_slave_if.slave (Pselx, Penable, Pwrite, Paddr,
//                     Pwdata in; Prdata, Pready, Pslverr out)
// Params   : WAIT_CYCLES (0..15), SLV_INDEX (0..2), ID_VALUE
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned SLV_INDEX   = 0,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic       Hclk,
  input  logic       Hreset,
  apb_slave_if.slave bus
);

  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES);

  apb_state_e         state, state_nx;
  logic [WCNT_W-1:0]  wcnt, wcnt_nx;

  logic [IDX_W-1:0]   cap_idx;
  logic               cap_write;
  logic [31:0]        cap_wdata;

  logic               sel;
  logic               setup;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_write;
  logic               entering_ready;
  logic               we;
  logic [31:0]        rf_rdata;

  logic               pready_q;
  logic               pslverr_q;
  logic [31:0]        prdata_q;

  // Only word-index bits and our own select bit carry meaning
  logic               unused_bus_bits;
  assign unused_bus_bits = ^{bus.Paddr[31:5], bus.Paddr[1:0], bus.Pselx};

  assign sel   = bus.Pselx[SLV_INDEX];
  assign setup = sel && !bus.Penable;

  // In IDLE the transfer is being set up this very cycle, so decode from the
  // live bus; afterwards only the values captured at SETUP are trusted.
  assign cur_idx   = (state == ST_IDLE) ? bus.Paddr[4:2] : cap_idx;
  assign cur_write = (state == ST_IDLE) ? bus.Pwrite     : cap_write;

  // Next-state and wait counter
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    case (state)
      ST_IDLE: begin
        // Penable without a prior SETUP falls through and is ignored
        if (setup) begin
          wcnt_nx  = WAIT_LOAD;
          state_nx = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!sel) begin
          state_nx = ST_IDLE;
          wcnt_nx  = '0;
        end else begin
          wcnt_nx = wcnt - WCNT_W'(1);
          if (wcnt == WCNT_W'(1)) begin
            state_nx = ST_READY;
          end
        end
      end
      ST_READY: begin
        state_nx = ST_IDLE;
        wcnt_nx  = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        wcnt_nx  = '0;
      end
    endcase
  end

  assign entering_ready = (state_nx == ST_READY);

  // Commit happens at the close of the single READY cycle, and only while
  // the bridge still holds the ACCESS phase for us.
  assign we = (state == ST_READY) && sel && bus.Penable && cap_write && !pslverr_q;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else if ((state == ST_IDLE) && setup) begin
      cap_idx   <= bus.Paddr[4:2];
      cap_write <= bus.Pwrite;
      cap_wdata <= bus.Pwdata;
    end
  end

  // Registered response: non-zero only while in READY
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= entering_ready;
      pslverr_q <= entering_ready && cur_write && is_id_word(cur_idx);
      prdata_q  <= (entering_ready && !cur_write) ? rf_rdata : '0;
    end
  end

  apb_slave_regfile #(
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk   (Hclk),
    .rst   (Hreset),
    .we    (we),
    .waddr (cap_idx),
    .wdata (cap_wdata),
    .raddr (cur_idx),
    .rdata (rf_rdata)
  );

  assign bus.Pready  = pready_q;
  assign bus.Pslverr = pslverr_q;
  assign bus.Prdata  = prdata_q;

endmodule : apb_slave
`default_nettype wire

// File: tb/tb_apb_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave
// Purpose  : Self-checking bench for apb_slave. Four completers with
//            WAIT_CYCLES = 0..3 share one bridge; a target mask routes each
//            transfer to exactly one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave;
  import apb_pkg::*;

  localparam int          NDUT = 4;
  localparam logic [31:0] ID   = 32'hA0B0_0001;

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  logic              Hclk        = 1'b0;
  logic              Hreset      = 1'b1;
  logic [2:0]        psel_drv    = '0;
  logic              penable     = 1'b0;
  logic              pwrite      = 1'b0;
  logic [31:0]       paddr       = '0;
  logic [31:0]       pwdata      = '0;
  logic [NDUT-1:0]   target_mask = '0;

  logic [31:0]       rd [NDUT];
  logic [NDUT-1:0]   rdy;
  logic [NDUT-1:0]   errv;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference contents of every completer's bank (word 7 never stored)
  logic [31:0] model_mem [NDUT][8];

  always #5 Hclk = ~Hclk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    apb_slave_if bus ();
    assign bus.Pselx   = target_mask[k] ? psel_drv : 3'b000;
    assign bus.Penable = penable;
    assign bus.Pwrite  = pwrite;
    assign bus.Paddr   = paddr;
    assign bus.Pwdata  = pwdata;
    assign rd[k]       = bus.Prdata;
    assign rdy[k]      = bus.Pready;
    assign errv[k]     = bus.Pslverr;

    apb_slave #(
      .WAIT_CYCLES (k),
      .SLV_INDEX   (k % 3),
      .ID_VALUE    (ID)
    ) dut (
      .Hclk   (Hclk),
      .Hreset (Hreset),
      .bus    (bus)
    );
  end

  // ---------------------------------------------------------------- model
  function automatic int word_of(input logic [31:0] a);
    return int'(a % 32) / 4;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int w;
    w = word_of(a);
    if (w == 7) return ID;
    return model_mem[d][w];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data);
    int w;
    w = word_of(a);
    if (w != 7) model_mem[d][w] = data;
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < 8; w++)
        model_mem[d][w] = '0;
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    psel_drv    = '0;
    penable     = 1'b0;
    target_mask = '0;
  endtask

  task automatic select(input int d);
    target_mask    = '0;
    target_mask[d] = 1'b1;
    psel_drv       = '0;
    psel_drv[d % 3] = 1'b1;
  endtask

  // One complete bridge transfer; Paddr/Pwdata are scrambled during ACCESS
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata,
                      output bit err, output int lat);
    bit ok;
    ok    = 1'b0;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    @(negedge Hclk);
    check("pready_single_cycle", {28'd0, rdy}, 32'd0);
    select(d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge Hclk);
      penable = 1'b1;
      if (rdy[d]) begin
        ok    = 1'b1;
        rdata = rd[d];
        err   = errv[d];
      end else begin
        lat++;
      end
      paddr  = $urandom;
      pwdata = $urandom;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL xfer_timeout: dut=%0d actual=no Pready in 40 cycles required=Pready", d);
      drive_idle();
    end
  endtask

  task automatic run_check(input string tag, input int d, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_rd, input bit exp_err,
                           input int exp_lat);
    logic [31:0] r;
    bit          e;
    int          l;
    xfer(d, wr, addr, data, r, e, l);
    check({tag, "_latency"}, l, exp_lat);
    check({tag, "_pslverr"}, {31'd0, e}, {31'd0, exp_err});
    if (!wr) check({tag, "_prdata"}, r, exp_rd);
  endtask

  // ---------------------------------------------------------------- test
  vec_t vecs [10];

  initial begin
    logic [31:0] a, wd, exp_rd;
    int          d;
    bit          wr, exp_err;

    vecs[0] = '{0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
    vecs[1] = '{0, 1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[2] = '{3, 1'b0, 32'h0000_001C, 32'h0,         32'hA0B0_0001, 1'b0, 3};
    vecs[3] = '{3, 1'b1, 32'h0000_001C, 32'h0000_1234, 32'h0,         1'b1, 3};
    vecs[4] = '{3, 1'b0, 32'h0000_001C, 32'h0,         32'hA0B0_0001, 1'b0, 3};
    vecs[5] = '{1, 1'b1, 32'h0000_0008, 32'h5A5A_0008, 32'h0,         1'b0, 1};
    vecs[6] = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'h5A5A_0008, 1'b0, 1};
    vecs[7] = '{0, 1'b1, 32'hABC0_0010, 32'h0000_1111, 32'h0,         1'b0, 0};
    vecs[8] = '{0, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_1111, 1'b0, 0};
    vecs[9] = '{2, 1'b0, 32'h0000_0018, 32'h0,         32'h0,         1'b0, 2};

    model_reset();

    // Reset state
    Hreset = 1'b1;
    repeat (3) @(negedge Hclk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset_pready_%0d", k),  {31'd0, rdy[k]},  32'd0);
      check($sformatf("reset_pslverr_%0d", k), {31'd0, errv[k]}, 32'd0);
      check($sformatf("reset_prdata_%0d", k),  rd[k],            32'd0);
    end
    Hreset = 1'b0;

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].dut, vecs[i].wr, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
      if (vecs[i].wr) model_write(vecs[i].dut, vecs[i].addr, vecs[i].wdata);
    end

    // Select dropped in the 2nd ACCESS cycle of a 2-wait write
    @(negedge Hclk);
    select(2);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55;
    @(negedge Hclk);
    penable = 1'b1;
    check("abort_access1_pready", {31'd0, rdy[2]}, 32'd0);
    @(negedge Hclk);
    psel_drv = '0;
    check("abort_access2_pready", {31'd0, rdy[2]}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge Hclk);
      check("abort_no_pready", {31'd0, rdy[2]}, 32'd0);
    end
    run_check("abort_readback", 2, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 2);

    // Penable without SETUP, then a SETUP on the wrong select bit
    @(negedge Hclk);
    select(0);
    penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hBAD0_0BAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge Hclk);
      check("stray_enable_pready", {31'd0, rdy[0]}, 32'd0);
    end
    psel_drv = 3'b110;
    penable  = 1'b0;
    @(negedge Hclk);
    penable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Hclk);
      check("wrong_select_pready", {31'd0, rdy[0]}, 32'd0);
    end
    run_check("stray_readback", 0, 1'b0, 32'h0, 32'h0, model_read(0, 32'h0), 1'b0, 0);

    // Reset asserted while READY is showing: outputs clear without a clock
    @(negedge Hclk);
    select(0);
    penable = 1'b0; pwrite = 1'b0; paddr = 32'h1C;
    @(negedge Hclk);
    penable = 1'b1;
    check("pre_reset_pready", {31'd0, rdy[0]}, 32'd1);
    check("pre_reset_prdata", rd[0], ID);
    #2;
    Hreset = 1'b1;
    drive_idle();
    #1;
    check("async_clear_pready", {31'd0, rdy[0]}, 32'd0);
    check("async_clear_prdata", rd[0], 32'd0);
    model_reset();
    @(negedge Hclk);
    Hreset = 1'b0;

    // Reset while a 1-wait write of 0xFF to 0x0C sits in WAIT
    @(negedge Hclk);
    select(1);
    penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFF;
    @(negedge Hclk);
    penable = 1'b1;
    check("wait_pready_low", {31'd0, rdy[1]}, 32'd0);
    #2;
    Hreset = 1'b1;
    drive_idle();
    #1;
    check("reset_in_wait_pready",  {31'd0, rdy[1]},  32'd0);
    check("reset_in_wait_pslverr", {31'd0, errv[1]}, 32'd0);
    check("reset_in_wait_prdata",  rd[1],            32'd0);
    @(negedge Hclk);
    Hreset = 1'b0;
    model_reset();
    run_check("post_reset_read", 1, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 1);

    // Randomised traffic against the reference bank
    for (int i = 0; i < 150; i++) begin
      d  = $urandom_range(0, NDUT - 1);
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) a[4:2] = 3'd7;
      exp_rd  = model_read(d, a);
      exp_err = wr && (word_of(a) == 7);
      run_check("rand", d, wr, a, wd, exp_rd, exp_err, d);
      if (wr) model_write(d, a, wd);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge Hclk);
        drive_idle();
      end
    end

    @(negedge Hclk);
    drive_idle();
    @(negedge Hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apb_slave
`default_nettype wire

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: ACCESS-phase wait states inserted before Pready, range 0..15.
REQ-002 Parameter SLV_INDEX, default 0: bit of the bridge's Pselx[2:0] that selects this completer, range 0..2.
REQ-003 Parameter ID_VALUE, default 32'hA0B0_0001: constant returned by the read-only ID register.
REQ-004 Hclk  in  1  sole clock; all state updates on rising edge.
REQ-005 Hreset  in  1  asynchronous, active-high reset.
REQ-006 Pselx  in  3  bridge select bus; only bit SLV_INDEX is used.
REQ-007 Penable  in  1  APB enable (ACCESS phase).
REQ-008 Pwrite  in  1  1 = write, 0 = read.
REQ-009 Paddr  in  32  byte address; bits [4:2] index the word, other bits ignored.
REQ-010 Pwdata  in  32  write data.
REQ-011 Prdata  out  32  read data, valid when Pready=1 on a read.
REQ-012 Pready  out  1  transfer complete.
REQ-013 Pslverr  out  1  error response, valid when Pready=1.

Function
REQ-014 Register bank: 8 x 32-bit words; words 0..6 read/write; word 7 read-only, returns ID_VALUE.
REQ-015 FSM states: IDLE, WAIT, READY; encoding comes from the shared package.
REQ-016 IDLE: on a SETUP cycle (sel=Pselx[SLV_INDEX]=1, Penable=0), capture Paddr[4:2], Pwrite and Pwdata, and load wcnt=WAIT_CYCLES.
REQ-017 From that SETUP cycle, go to READY if WAIT_CYCLES=0, otherwise to WAIT.
REQ-018 WAIT: decrement wcnt each cycle; go to READY on the cycle wcnt=1.
REQ-019 WAIT: Pready=0 throughout.
REQ-020 Latency: Pready=1 exactly WAIT_CYCLES cycles after the first ACCESS cycle (WAIT_CYCLES=0 gives a zero-wait transfer).
REQ-021 READY: Pready=1 for exactly one cycle, then return to IDLE.
REQ-022 READY: a back-to-back SETUP in the cycle after READY is accepted from IDLE with no bubble.
REQ-023 Pready, Prdata and Pslverr are registered outputs, updated on entry to READY.
REQ-024 Pready, Prdata and Pslverr are 0 in every state other than READY.
REQ-025 Write commit: the captured data is written to the captured word on the READY cycle, only if sel=1, Penable=1 and Pslverr=0.
REQ-026 Write to word 7 -> Pslverr=1, no register changes.
REQ-027 Read of word 7 -> Prdata=ID_VALUE, Pslverr=0.
REQ-028 Read of words 0..6 -> Prdata = current content (reflects any write committed in an earlier transfer), Pslverr=0.
REQ-029 Protocol violation: sel deasserted while in WAIT or READY -> abort to IDLE next cycle, no write commit, outputs cleared.
REQ-030 Penable=1 while in IDLE without a preceding SETUP -> ignored, FSM stays in IDLE.
REQ-031 Paddr and Pwdata changing during ACCESS have no effect; the values captured at SETUP are used.

Reset
REQ-032 Hreset=1 forces asynchronously: FSM=IDLE, wcnt=0, Pready=0, Pslverr=0, Prdata=0, words 0..6 = 0.
REQ-033 Reset mid-transfer discards the pending write.
REQ-034 After reset release, the first SETUP is accepted normally.

Structure
REQ-035 Shared package apb_pkg holds: FSM state typedef/encodings, ID_VALUE default, register count (8), word-index width (3), ID word index (7).
REQ-036 One sub-module, apb_slave_regfile, holds storage, write enable and read mux; the FSM, wait counter and error decode stay in apb_slave.

Verification
REQ-037 WAIT_CYCLES=0: write 32'hDEAD_BEEF to Paddr=0x04, then read 0x04 -> each Pready in the first ACCESS cycle; Prdata=32'hDEAD_BEEF; Pslverr=0.
REQ-038 WAIT_CYCLES=3: read 0x1C -> Pready low for 3 ACCESS cycles, high on the 4th; Prdata=32'hA0B0_0001.
REQ-039 Write 32'h1234 to 0x1C -> Pslverr=1 with Pready; subsequent read of 0x1C still returns 32'hA0B0_0001.
REQ-040 WAIT_CYCLES=2: write 0x55 to 0x08, drop sel in the 2nd ACCESS cycle -> FSM returns to IDLE, Pready never asserts, read of 0x08 returns 0.
REQ-041 WAIT_CYCLES=1: assert Hreset while in WAIT of a write of 0xFF to 0x0C -> outputs 0 immediately, read of 0x0C after release returns 0.
REQ-042 Back-to-back transfers: write 0x08 then read 0x08 with no idle cycle between them -> read returns the written value.
